spram_stream_ctrl: RTL and testbench

Parametrised single-port SRAM controller with a valid/ready request channel and a response channel. Generalises the fixed 16x64 single-port wrapper in width and depth, and adds:
- per-byte write mask
- optional output register stage
- backpressure-safe response buffering
- post-reset zero-initialisation sequencer

Used wherever a core needs small local scratch or descriptor storage behind a stream interface.

---
 rtl/spram_stream_ctrl_if.sv | 27 ++
 rtl/spram_stream_ctrl.sv | 135 +++++++++++++
 tb/tb_spram_stream_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spram_stream_ctrl_if.sv
// Request/response bundle for spram_stream_ctrl.
// The master drives requests and rsp_ready; the slave (the controller) drives
// req_ready and the response channel.
interface spram_stream_ctrl_if #(
  parameter int DW = 64,
  parameter int AW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_bmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spram_stream_ctrl.sv
// Single-port SRAM controller behind a valid/ready request channel and a
// buffered response channel. Supports per-byte write masks, an optional
// output register stage and a post-reset zero-fill of the whole array.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; valid never waits on ready, and payload is sampled only
// on that edge. req_ready may depend combinationally on req_we.
module spram_stream_ctrl #(
  parameter int DW        = 64,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int OUT_REG   = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_done,
  output logic                 dbg_state,
  spram_stream_ctrl_if.slave   bus
);
  localparam int LAT = 1 + OUT_REG;
  localparam int FD  = LAT + 1;          // response FIFO depth
  localparam int PW  = $clog2(FD);
  localparam int CW  = $clog2(FD + 1);
  localparam int NB  = DW / 8;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            init_done_q, init_done_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            pipe_vld_q, pipe_vld_d;
  logic [DW-1:0]   pipe_data_q, pipe_data_d;

  logic [DW-1:0]   mem_q  [DEPTH];
  logic [DW-1:0]   fifo_q [FD];

  logic            addr_ok;
  logic [DW-1:0]   rd_data;
  logic            req_ready;
  logic            rd_acc, wr_acc, pop, push;
  logic [DW-1:0]   push_data;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  if (DEPTH == (1 << AW)) begin : g_full_range
    assign addr_ok = 1'b1;
  end else begin : g_part_range
    assign addr_ok = ({1'b0, bus.req_addr} < (AW+1)'(DEPTH));
  end

  assign rd_data       = addr_ok ? mem_q[bus.req_addr] : '0;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (fcnt_q != '0);
  assign bus.rsp_rdata = (fcnt_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign init_done     = init_done_q;
  assign dbg_state     = (state_q == ST_RUN);

  // Next-state, handshake and response-path bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready   = init_done_q && (bus.req_we || (credit_q < CW'(FD)));
    rd_acc      = bus.req_valid && req_ready && !bus.req_we;
    wr_acc      = bus.req_valid && req_ready && bus.req_we && addr_ok;
    pop         = (fcnt_q != '0) && bus.rsp_ready;
    pipe_vld_d  = (OUT_REG != 0) && rd_acc;
    pipe_data_d = rd_data;
    push        = (OUT_REG != 0) ? pipe_vld_q : rd_acc;
    push_data   = (OUT_REG != 0) ? pipe_data_q : rd_data;

    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
    init_done_d = (state_d == ST_RUN);

    credit_d = credit_q + CW'(rd_acc) - CW'(pop);
    fcnt_d   = fcnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

  // Control registers; reset flushes in-flight reads and the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      credit_q    <= '0;
      fcnt_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      credit_q    <= credit_d;
      fcnt_q      <= fcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  // Array write port: zero-fill during INIT, masked writes in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.req_bmask[i]) mem_q[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response FIFO storage; occupancy is tracked by fcnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: tb/tb_spram_stream_ctrl.sv
// Directed bench for spram_stream_ctrl: one instance with DEPTH=16/OUT_REG=1
// and one with DEPTH=12/OUT_REG=0. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_spram_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  logic init_done_a, init_done_b, dbg_a, dbg_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [63:0] D3 = 64'h11223344AAAAAAAA;
  localparam logic [63:0] DX = 64'h0123456789ABCDEF;

  // Clock
  always #5 clk = ~clk;

  spram_stream_ctrl_if #(.DW(64), .AW(4)) ia ();
  spram_stream_ctrl_if #(.DW(64), .AW(4)) ib ();

  spram_stream_ctrl #(.DW(64), .DEPTH(16), .AW(4), .OUT_REG(1), .INIT_ZERO(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .init_done(init_done_a), .dbg_state(dbg_a), .bus(ia)
  );

  spram_stream_ctrl #(.DW(64), .DEPTH(12), .AW(4), .OUT_REG(0), .INIT_ZERO(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .init_done(init_done_b), .dbg_state(dbg_b), .bus(ib)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instance A drivers (latency 2)
  task automatic wr_a(input logic [3:0] a, input logic [63:0] d, input logic [7:0] m, input string tag);
    @(negedge clk);
    ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = a; ia.req_wdata = d; ia.req_bmask = m;
    #1 chk({tag, "_rdy"}, 64'(ia.req_ready), 64'd1);
    @(negedge clk);
    ia.req_valid = 1'b0; ia.req_we = 1'b0;
  endtask

  task automatic rd_a(input logic [3:0] a, input logic [63:0] exp, input string tag);
    @(negedge clk);
    ia.req_valid = 1'b1; ia.req_we = 1'b0; ia.req_addr = a;
    #1 chk({tag, "_rdy"}, 64'(ia.req_ready), 64'd1);
    @(negedge clk);
    ia.req_valid = 1'b0;
    chk({tag, "_early"}, 64'(ia.rsp_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(ia.rsp_valid), 64'd1);
    chk({tag, "_data"}, ia.rsp_rdata, exp);
  endtask

  task automatic init_a(input string tag);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk({tag, "_done"}, 64'(init_done_a), 64'(k == 16));
      chk({tag, "_rdy"}, 64'(ia.req_ready), 64'(k == 16));
      chk({tag, "_state"}, 64'(dbg_a), 64'(k == 16));
      chk({tag, "_rspv"}, 64'(ia.rsp_valid), 64'd0);
    end
  endtask

  // Instance B drivers (latency 1)
  task automatic wr_b(input logic [3:0] a, input logic [63:0] d, input logic [7:0] m, input string tag);
    @(negedge clk);
    ib.req_valid = 1'b1; ib.req_we = 1'b1; ib.req_addr = a; ib.req_wdata = d; ib.req_bmask = m;
    #1 chk({tag, "_rdy"}, 64'(ib.req_ready), 64'd1);
    @(negedge clk);
    ib.req_valid = 1'b0; ib.req_we = 1'b0;
  endtask

  task automatic rd_b(input logic [3:0] a, input logic [63:0] exp, input string tag);
    @(negedge clk);
    ib.req_valid = 1'b1; ib.req_we = 1'b0; ib.req_addr = a;
    #1 chk({tag, "_rdy"}, 64'(ib.req_ready), 64'd1);
    @(negedge clk);
    ib.req_valid = 1'b0;
    chk({tag, "_vld"}, 64'(ib.rsp_valid), 64'd1);
    chk({tag, "_data"}, ib.rsp_rdata, exp);
  endtask

  initial begin
    ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_addr = '0; ia.req_wdata = '0; ia.req_bmask = '0;
    ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_addr = '0; ib.req_wdata = '0; ib.req_bmask = '0;
    ia.rsp_ready = 1'b1; ib.rsp_ready = 1'b1;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_done", 64'(init_done_a), 64'd0);
    chk("rst_rdy", 64'(ia.req_ready), 64'd0);
    chk("rst_rspv", 64'(ia.rsp_valid), 64'd0);
    chk("rst_rdata", ia.rsp_rdata, 64'd0);
    chk("rst_state", 64'(dbg_a), 64'd0);

    // Zero-fill takes exactly 16 cycles, then every word reads back zero
    rst_n_a = 1'b1;
    init_a("init1");
    for (int a = 0; a < 16; a++) rd_a(4'(a), 64'd0, "zero_rd");

    // Byte-masked overwrite
    wr_a(4'd3, 64'h1122334455667788, 8'hFF, "w3_full");
    wr_a(4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, "w3_low");
    rd_a(4'd3, D3, "bmask_rd");

    // Read in the cycle right after a write to the same address
    @(negedge clk);
    ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = 4'd5;
    ia.req_wdata = 64'hDEADBEEF0BADF00D; ia.req_bmask = 8'hFF;
    @(negedge clk);
    ia.req_we = 1'b0;
    #1 chk("raw_rdy", 64'(ia.req_ready), 64'd1);
    @(negedge clk);
    ia.req_valid = 1'b0;
    chk("raw_early", 64'(ia.rsp_valid), 64'd0);
    @(negedge clk);
    chk("raw_vld", 64'(ia.rsp_valid), 64'd1);
    chk("raw_data", ia.rsp_rdata, 64'hDEADBEEF0BADF00D);

    // Zero mask leaves the word untouched
    wr_a(4'd5, 64'hFFFFFFFFFFFFFFFF, 8'h00, "w5_nomask");
    rd_a(4'd5, 64'hDEADBEEF0BADF00D, "bmask0_rd");

    // Backpressure: three reads fill the credit, the fourth waits
    wr_a(4'd0, 64'hA0, 8'hFF, "w0");
    wr_a(4'd1, 64'hA1, 8'hFF, "w1");
    wr_a(4'd2, 64'hA2, 8'hFF, "w2");
    @(negedge clk);
    ia.rsp_ready = 1'b0;
    ia.req_valid = 1'b1; ia.req_we = 1'b0; ia.req_addr = 4'd0;
    #1 chk("bp_rdy0", 64'(ia.req_ready), 64'd1);
    @(negedge clk); ia.req_addr = 4'd1;
    #1 chk("bp_rdy1", 64'(ia.req_ready), 64'd1);
    @(negedge clk); ia.req_addr = 4'd2;
    #1 chk("bp_rdy2", 64'(ia.req_ready), 64'd1);
    @(negedge clk); ia.req_addr = 4'd3;
    #1 chk("bp_full0", 64'(ia.req_ready), 64'd0);
    @(negedge clk);
    chk("bp_full1", 64'(ia.req_ready), 64'd0);
    @(negedge clk);
    chk("bp_full2", 64'(ia.req_ready), 64'd0);
    chk("bp_vld", 64'(ia.rsp_valid), 64'd1);
    chk("bp_d0", ia.rsp_rdata, 64'hA0);
    ia.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_d1", ia.rsp_rdata, 64'hA1);
    chk("bp_rdy_again", 64'(ia.req_ready), 64'd1);
    @(negedge clk);
    ia.req_valid = 1'b0;
    chk("bp_d2", ia.rsp_rdata, 64'hA2);
    @(negedge clk);
    chk("bp_d3_vld", 64'(ia.rsp_valid), 64'd1);
    chk("bp_d3", ia.rsp_rdata, D3);
    @(negedge clk);
    chk("bp_drained", 64'(ia.rsp_valid), 64'd0);

    // Reset with two reads in flight flushes them
    wr_a(4'd12, 64'hCAFEF00DCAFEF00D, 8'hFF, "w12");
    @(negedge clk);
    ia.rsp_ready = 1'b0;
    ia.req_valid = 1'b1; ia.req_we = 1'b0; ia.req_addr = 4'd0;
    @(negedge clk); ia.req_addr = 4'd1;
    @(negedge clk);
    ia.req_valid = 1'b0;
    chk("pre_rst_vld", 64'(ia.rsp_valid), 64'd1);
    rst_n_a = 1'b0;
    @(negedge clk);
    chk("flush_vld", 64'(ia.rsp_valid), 64'd0);
    chk("flush_rdy", 64'(ia.req_ready), 64'd0);
    chk("flush_done", 64'(init_done_a), 64'd0);
    rst_n_a = 1'b1;
    init_a("init2");

    // Reset at INIT cycle 7 restarts the full zero-fill
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    repeat (7) @(negedge clk);
    rst_n_a = 1'b0;
    @(negedge clk);
    chk("midinit_done", 64'(init_done_a), 64'd0);
    chk("midinit_state", 64'(dbg_a), 64'd0);
    rst_n_a = 1'b1;
    init_a("init3");
    ia.rsp_ready = 1'b1;
    rd_a(4'd12, 64'd0, "refill12");
    rd_a(4'd3, 64'd0, "refill3");
    rd_a(4'd15, 64'd0, "refill15");

    // Instance B: DEPTH=12, latency 1
    rst_n_b = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("b_init_done", 64'(init_done_b), 64'(k == 12));
      chk("b_init_state", 64'(dbg_b), 64'(k == 12));
    end
    wr_b(4'd4, DX, 8'hFF, "b_w4");
    wr_b(4'd13, 64'hFFFFFFFFFFFFFFFF, 8'hFF, "b_w13");
    rd_b(4'd13, 64'd0, "b_oob13");
    rd_b(4'd4, DX, "b_rd4");
    rd_b(4'd11, 64'd0, "b_rd11");
    rd_b(4'd1, 64'd0, "b_rd1");
    wr_b(4'd3, 64'h1122334455667788, 8'hFF, "b_w3_full");
    wr_b(4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, "b_w3_low");
    rd_b(4'd3, D3, "b_bmask_rd");

    // Instance B backpressure: two reads fill the credit
    @(negedge clk);
    ib.rsp_ready = 1'b0;
    ib.req_valid = 1'b1; ib.req_we = 1'b0; ib.req_addr = 4'd4;
    #1 chk("b_bp_rdy0", 64'(ib.req_ready), 64'd1);
    @(negedge clk); ib.req_addr = 4'd11;
    #1 chk("b_bp_rdy1", 64'(ib.req_ready), 64'd1);
    @(negedge clk); ib.req_addr = 4'd3;
    #1 chk("b_bp_full", 64'(ib.req_ready), 64'd0);
    chk("b_bp_head0", ib.rsp_rdata, DX);
    ib.rsp_ready = 1'b1;
    @(negedge clk);
    chk("b_bp_vld1", 64'(ib.rsp_valid), 64'd1);
    chk("b_bp_head1", ib.rsp_rdata, 64'd0);
    chk("b_bp_rdy2", 64'(ib.req_ready), 64'd1);
    @(negedge clk);
    ib.req_valid = 1'b0;
    chk("b_bp_vld2", 64'(ib.rsp_valid), 64'd1);
    chk("b_bp_head2", ib.rsp_rdata, D3);
    @(negedge clk);
    chk("b_bp_drained", 64'(ib.rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
